// File: rtl/alu_pkg.sv
// ALU opcode constants and the sequential multiplier state encoding.
// Shared by mul_seq and its bench.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_ADD,
      S_DONE
   } mul_state_t;

endpackage

// File: rtl/mul_seq.sv
// Shift-and-add multiplier driving an external ALU; low WIDTH bits kept.
// Optional MUL_SEQ_EARLY_EXIT_EN: finish as soon as the multiplier is 0.
module mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic [3:0]       o_alu_control,
   output logic [WIDTH-1:0] o_alu_a,
   output logic [WIDTH-1:0] o_alu_b,
   input  logic [WIDTH-1:0] i_alu_result,
   input  logic             i_alu_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   mul_state_t       state;
   mul_state_t       state_next;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   logic             load;
   logic             shift;
   logic             add;

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next state, handshake and ALU request decode.
   always_comb begin
      state_next    = state;
      o_ready       = 1'b0;
      o_alu_control = ALU_AND;
      o_alu_a       = '0;
      o_alu_b       = '0;
      load          = 1'b0;
      shift         = 1'b0;
      add           = 1'b0;
      unique case (state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               load       = 1'b1;
               state_next = S_CHECK;
            end
         end
         S_CHECK: begin
            if (cnt == CW'(WIDTH)) begin
               state_next = S_DONE;
            end
`ifdef MUL_SEQ_EARLY_EXIT_EN
            else if (mplier == '0) begin
               state_next = S_DONE;
            end
`endif
            else begin
               o_alu_control = ALU_AND;
               o_alu_a       = mplier;
               o_alu_b       = WIDTH'(1);
               if (!i_alu_zero) state_next = S_ADD;
               else             shift      = 1'b1;
            end
         end
         S_ADD: begin
            o_alu_control = ALU_ADD;
            o_alu_a       = acc;
            o_alu_b       = mcand;
            add           = 1'b1;
            shift         = 1'b1;
            state_next    = S_CHECK;
         end
         S_DONE: begin
            if (i_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Operand, accumulator and result registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         o_valid  <= 1'b0;
         o_result <= '0;
      end else begin
         if (load) begin
            acc    <= '0;
            mcand  <= i_a;
            mplier <= i_b;
            cnt    <= '0;
         end
         if (add) acc <= i_alu_result;
         if (shift) begin
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
         end
         o_valid <= (state_next == S_DONE);
         if (state == S_CHECK && state_next == S_DONE)
            o_result <= acc;
      end
   end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq with a behavioural ALU attached.
// Expected latencies follow MUL_SEQ_EARLY_EXIT_EN when it is defined.
module tb_mul_seq;
   import alu_pkg::*;

   localparam int W = 64;
`ifdef MUL_SEQ_EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] i_a;
   logic [W-1:0] i_b;
   logic         o_valid;
   logic         i_ready;
   logic [W-1:0] o_result;
   logic [3:0]   alu_ctl;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [W-1:0] alu_res;
   logic         alu_zero;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      int           lat;
   } vec_t;

   vec_t         vecs[$];
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   mul_seq #(.WIDTH(W)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_a           (i_a),
      .i_b           (i_b),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_result      (o_result),
      .o_alu_control (alu_ctl),
      .o_alu_a       (alu_a),
      .o_alu_b       (alu_b),
      .i_alu_result  (alu_res),
      .i_alu_zero    (alu_zero)
   );

   // Combinational ALU.
   always_comb begin
      alu_res = '0;
      case (alu_ctl)
         ALU_AND: alu_res = alu_a & alu_b;
         ALU_OR:  alu_res = alu_a | alu_b;
         ALU_ADD: alu_res = alu_a + alu_b;
         ALU_SUB: alu_res = alu_a - alu_b;
         default: alu_res = '0;
      endcase
      alu_zero = (alu_res == '0);
   end

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int model_lat(input logic [W-1:0] b);
      int pop = 0;
      int msb = -1;
      for (int i = 0; i < W; i++)
         if (b[i]) begin
            pop++;
            msb = i;
         end
      if (!EE) return W + 1 + pop;
      if (msb < 0) return 1;
      return msb + 2 + pop;
   endfunction

   // Issue one request, measure latency, compare against the scoreboard.
   task automatic run_op(input string name, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res,
                         input int lat);
      int n;
      logic [W-1:0] exp;
      @(negedge clk);
      chk({name, "_ready"}, W'(o_ready), W'(1));
      i_a     = a;
      i_b     = b;
      i_valid = 1'b1;
      exp_q.push_back(res);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({name, "_lat"}, W'(n), W'(lat));
      if (exp_q.size() == 0) begin
         chk({name, "_sb_empty"}, W'(1), W'(0));
      end else begin
         exp = exp_q.pop_front();
         chk({name, "_res"}, o_result, exp);
      end
      if (!i_ready) begin
         @(negedge clk);
         i_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      chk({name, "_taken"}, W'({o_valid, o_ready}), W'(2'b01));
   endtask

   initial begin
      int n;
      bit seen;
      logic [W-1:0] a;
      logic [W-1:0] b;

      vecs.push_back('{64'd3, 64'd5, 64'd15, EE ? 6 : 67});
      vecs.push_back('{64'h8000_0000_0000_0000, 64'd2, 64'd0,
                       EE ? 4 : 66});
      vecs.push_back('{64'd7, 64'd0, 64'd0, EE ? 1 : 65});
      vecs.push_back('{'1, '1, 64'd1, 129});
      vecs.push_back('{64'd1, 64'h8000_0000_0000_0000,
                       64'h8000_0000_0000_0000, EE ? 66 : 66});
      for (int i = 0; i < 4; i++) begin
         a = {$urandom, $urandom};
         b = 64'($urandom_range(0, 65535));
         vecs.push_back('{a, b, a * b, model_lat(b)});
      end

      rst     = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_a     = '0;
      i_b     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_ready", W'(o_ready), W'(1));
      chk("rst_valid", W'(o_valid), W'(0));
      chk("rst_alu_ctl", W'(alu_ctl), W'(0));
      chk("rst_alu_ab", alu_a | alu_b, '0);
      chk("rst_result", o_result, '0);

      for (int i = 0; i < vecs.size(); i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                vecs[i].res, vecs[i].lat);

      // Result held while the consumer stalls; new request ignored.
      @(negedge clk);
      i_ready = 1'b0;
      i_a     = 64'd6;
      i_b     = 64'd7;
      i_valid = 1'b1;
      exp_q.push_back(64'd42);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("hold_lat", W'(n), W'(EE ? 7 : 68));
      i_a     = 64'd9;
      i_b     = 64'd9;
      i_valid = 1'b1;
      seen    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (!o_valid || o_ready || o_result !== 64'd42) seen = 1'b1;
      end
      chk("hold_stable", W'(seen), W'(0));
      chk("hold_res", o_result, exp_q.size() ? exp_q.pop_front() : '1);
      @(negedge clk);
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("hold_taken", W'({o_valid, o_ready}), W'(2'b01));
      @(posedge clk);
      #1;
      chk("hold_no_accept", W'({o_valid, o_ready}), W'(2'b01));

      // Reset during an ADD aborts without a result.
      @(negedge clk);
      i_a     = 64'd6;
      i_b     = 64'd7;
      i_valid = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      n = 0;
      while (alu_ctl !== ALU_ADD && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("abort_saw_add", W'(alu_ctl), W'(ALU_ADD));
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_idle", W'({o_valid, o_ready, alu_ctl}),
          W'({1'b0, 1'b1, 4'b0000}));
      seen = 1'b0;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk);
         #1;
         if (o_valid) seen = 1'b1;
      end
      chk("abort_no_result", W'(seen), W'(0));
      chk("sb_drained", W'(exp_q.size()), W'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have a parameter WIDTH, default 64: operand, accumulator and result width.
REQ-002 SHALL have port i_clk, input, 1: the only clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports i_valid (input, 1) and o_ready (output, 1): the request handshake.
REQ-005 SHALL have ports i_a and i_b, input, WIDTH: the unsigned multiplicand and multiplier.
REQ-006 SHALL have port o_valid, output, 1: the result handshake.
REQ-007 SHALL have port i_ready, input, 1: the result handshake.
REQ-008 SHALL have port o_result, output, WIDTH: the low WIDTH bits of i_a*i_b.
REQ-009 SHALL have port o_alu_control, output, 4: the operation code driven to the external ALU.
REQ-010 SHALL have ports o_alu_a and o_alu_b, output, WIDTH: the ALU operands.
REQ-011 SHALL have port i_alu_result, input, WIDTH: the combinational ALU result.
REQ-012 SHALL have port i_alu_zero, input, 1: high when i_alu_result equals zero.

Function
REQ-013 SHALL be the initiator of the ALU interface, using codes ADD=0010 and AND=0000; SUB=0110 and OR=0001 are unused.
REQ-014 SHALL implement states IDLE, CHECK, ADD and DONE.
REQ-015 IDLE: o_ready=1; when i_valid=1, SHALL load acc=0, mcand=i_a, mplier=i_b and go to CHECK.
REQ-016 CHECK: SHALL drive AND with o_alu_a=mplier and o_alu_b=1.
REQ-017 CHECK: if i_alu_zero=0, SHALL go to ADD.
REQ-018 CHECK: if i_alu_zero=0 is false, SHALL shift mcand left 1, shift mplier right 1, increment the bit count and stay in CHECK.
REQ-019 ADD: SHALL drive ADD with o_alu_a=acc and o_alu_b=mcand, capture acc=i_alu_result, shift mcand and mplier, increment the bit count and return to CHECK.
REQ-020 SHALL leave CHECK for DONE, with no ALU operation, when the bit count reaches WIDTH.
REQ-021 SHALL discard carry-out, so the result wraps modulo 2^WIDTH.
REQ-022 DONE: SHALL hold o_valid=1 and o_result=acc stable until i_ready=1, then go to IDLE.
REQ-023 SHALL allow a new request to be accepted no earlier than the cycle after the result is taken.
REQ-024 SHALL hold o_ready=0 in every state except IDLE and SHALL ignore i_valid there.
REQ-025 In IDLE and DONE, SHALL drive o_alu_control=0000 with o_alu_a and o_alu_b equal to 0.
REQ-026 SHALL complete in (CHECK cycles + number of 1 bits processed) cycles after acceptance.

Reset
REQ-027 On i_rst=1, SHALL set state=IDLE.
REQ-028 On i_rst=1, SHALL clear o_valid, o_result, acc, mcand, mplier and the bit count to 0.
REQ-029 After reset, SHALL drive o_ready=1 and o_alu_control=0000.
REQ-030 Reset mid-operation SHALL abort the operation without producing a result.
REQ-031 Reset SHALL take priority over i_valid and i_ready in the same cycle.

Configuration
REQ-032 SHALL support the macro MUL_SEQ_EARLY_EXIT_EN.
REQ-033 When MUL_SEQ_EARLY_EXIT_EN is defined, CHECK SHALL also go to DONE when mplier==0, with no ALU operation; that cycle counts as one CHECK cycle.
REQ-034 When MUL_SEQ_EARLY_EXIT_EN is undefined, SHALL always process exactly WIDTH bits, giving a latency of WIDTH+1 plus popcount(i_b) cycles.

Structure
REQ-035 Package alu_pkg SHALL hold the ALU opcode constants (ADD, SUB, AND, OR) and the mul_seq state enum.
REQ-036 SHALL contain no sub-modules.
REQ-037 The bench SHALL instantiate the existing ALU and connect it to the o_alu_*/i_alu_* ports.

Verification
REQ-038 Bench SHALL check: reset then idle -> o_ready=1, o_valid=0, o_alu_control=0000.
REQ-039 Bench SHALL check: 3*5 with EARLY_EXIT -> o_valid rises 6 cycles after acceptance and o_result=15.
REQ-040 Bench SHALL check: 3*5 without EARLY_EXIT -> o_valid rises 67 cycles after acceptance and o_result=15.
REQ-041 Bench SHALL check: 0x8000_0000_0000_0000*2 -> o_result=0, confirming wrap.
REQ-042 Bench SHALL check: 7*0 with EARLY_EXIT -> o_valid rises 1 cycle after acceptance and o_result=0.
REQ-043 Bench SHALL check: 6*7 with i_ready=0 for 10 cycles -> o_valid and o_result=42 held, o_ready=0, and a second i_valid ignored.
REQ-044 Bench SHALL check: 6*7 then i_rst during ADD -> state IDLE and o_valid=0 next cycle, with no result produced.
